// File: rtl/encode_6466b_tx.sv
// rtl/encode_6466b_tx.sv - XGMII to 64b/66b transmit encoder, one-cycle latency.
// Define ENCODER_TX_SM_EN to add the C/S/D/T/E transmit sequencing state machine.
module encode_6466b_tx (
  input  logic        i_txc,
  input  logic        i_reset_n,
  input  logic        i_init_done,
  input  logic [63:0] i_txd,
  input  logic [7:0]  i_txctl,
  input  logic        i_tx_valid,
  output logic [63:0] o_txd,
  output logic [1:0]  o_tx_header,
  output logic        o_tx_valid
);
  localparam logic [1:0]  SYNC_DATA  = 2'b01;
  localparam logic [1:0]  SYNC_CTL   = 2'b10;
  localparam logic [7:0]  BT_IDLE    = 8'h1E;
  localparam logic [7:0]  BT_S0      = 8'h78;
  localparam logic [7:0]  BT_S4      = 8'h33;
  localparam logic [7:0]  BT_O0      = 8'h4B;
  localparam logic [7:0]  BT_O4      = 8'h2D;
  localparam logic [7:0]  BT_O0S4    = 8'h66;
  localparam logic [7:0]  BT_O0O4    = 8'h55;
  localparam logic [7:0]  CH_IDLE    = 8'h07;
  localparam logic [7:0]  CH_START   = 8'hFB;
  localparam logic [7:0]  CH_TERM    = 8'hFD;
  localparam logic [7:0]  CH_SEQ     = 8'h9C;
  localparam logic [63:0] IDLE_BLOCK = 64'h0000_0000_0000_001E;
  // Type 0x1E followed by eight 7-bit error codes (0x1E) at 8+7n.
  localparam logic [63:0] EBLOCK_T   = 64'h3C78_F1E3_C78F_1E1E;

  typedef enum logic [2:0] {CLS_C, CLS_S, CLS_D, CLS_T, CLS_E} cls_t;

  function automatic logic [7:0] term_type(input logic [2:0] k);
    case (k)
      3'd0:    term_type = 8'h87;
      3'd1:    term_type = 8'h99;
      3'd2:    term_type = 8'hAA;
      3'd3:    term_type = 8'hB4;
      3'd4:    term_type = 8'hCC;
      3'd5:    term_type = 8'hD2;
      3'd6:    term_type = 8'hE1;
      default: term_type = 8'hFF;
    endcase
  endfunction

  logic        r_rst_sync;
  logic [63:0] r_txd;
  logic [1:0]  r_tx_header;
  logic        r_tx_valid;
  logic [7:0]  w_lane [8];
  logic [6:0]  w_code [8];
  logic        w_lo_c, w_lo_o, w_up_c, w_up_o, w_up_s, w_t_hit;
  logic [2:0]  w_t_lane;
  logic [63:0] w_enc;
  logic [1:0]  w_enc_hdr;
  cls_t        w_cls;
  logic        w_force_e;

  always_comb begin
    for (int n = 0; n < 8; n++) begin
      w_lane[n] = i_txd[8*n +: 8];
      w_code[n] = (w_lane[n] == CH_IDLE) ? 7'h00 : 7'h1E;
    end
  end

  always_comb begin
    w_lo_c   = (i_txctl[3:0] == 4'hF);
    w_up_c   = (i_txctl[7:4] == 4'hF);
    w_t_hit  = 1'b0;
    w_t_lane = 3'd0;
    // Start/terminate characters outside their legal positions poison a control half.
    for (int n = 0; n < 8; n++) begin
      if (w_lane[n] == CH_START || w_lane[n] == CH_TERM) begin
        if (n < 4) w_lo_c = 1'b0;
        else       w_up_c = 1'b0;
      end
      if (i_txctl == 8'(8'hFF << n) && w_lane[n] == CH_TERM) begin
        w_t_hit  = 1'b1;
        w_t_lane = 3'(n);
      end
    end
    w_lo_o = (i_txctl[3:0] == 4'h1) && (w_lane[0] == CH_SEQ);
    w_up_o = (i_txctl[7:4] == 4'h1) && (w_lane[4] == CH_SEQ);
    w_up_s = (i_txctl[7:4] == 4'h1) && (w_lane[4] == CH_START);
  end

  always_comb begin
    w_enc     = EBLOCK_T;
    w_enc_hdr = SYNC_CTL;
    w_cls     = CLS_E;
    if (i_txctl == 8'h00) begin
      w_enc     = i_txd;
      w_enc_hdr = SYNC_DATA;
      w_cls     = CLS_D;
    end else if (i_txctl == 8'h01 && w_lane[0] == CH_START) begin
      w_enc = {i_txd[63:8], BT_S0};
      w_cls = CLS_S;
    end else if (w_t_hit) begin
      w_enc = {56'h0, term_type(w_t_lane)};
      for (int n = 0; n < 7; n++)
        if (n < int'(w_t_lane)) w_enc[8+8*n +: 8] = w_lane[n];
      for (int n = 1; n < 8; n++)
        if (n > int'(w_t_lane)) w_enc[8+7*n +: 7] = w_code[n];
      w_cls = CLS_T;
    end else if ((w_lo_c || w_lo_o) && (w_up_c || w_up_o || w_up_s)) begin
      w_enc = '0;
      if (w_lo_c) for (int n = 0; n < 4; n++) w_enc[8+7*n +: 7] = w_code[n];
      else        w_enc[31:8] = i_txd[31:8];
      if (w_up_c) for (int n = 4; n < 8; n++) w_enc[8+7*n +: 7] = w_code[n];
      else        w_enc[63:40] = i_txd[63:40];
      if (w_lo_c) w_enc[7:0] = w_up_c ? BT_IDLE : (w_up_o ? BT_O4 : BT_S4);
      else        w_enc[7:0] = w_up_c ? BT_O0 : (w_up_o ? BT_O0O4 : BT_O0S4);
      w_cls = w_up_s ? CLS_S : CLS_C;
    end
  end

`ifdef ENCODER_TX_SM_EN
  typedef enum logic [2:0] {TX_INIT, TX_C, TX_D, TX_T, TX_E} tx_state_t;
  tx_state_t r_state, w_state_nxt;

  always_ff @(posedge i_txc or negedge i_reset_n) begin
    if (!i_reset_n)                      r_state <= TX_INIT;
    else if (!r_rst_sync || !i_init_done) r_state <= TX_INIT;
    else if (i_tx_valid)                 r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = TX_E;
    case (r_state)
      TX_D: begin
        if (w_cls == CLS_D)      w_state_nxt = TX_D;
        else if (w_cls == CLS_T) w_state_nxt = TX_T;
      end
      TX_E: begin
        if (w_cls == CLS_C)      w_state_nxt = TX_C;
        else if (w_cls == CLS_D) w_state_nxt = TX_D;
        else if (w_cls == CLS_T) w_state_nxt = TX_T;
      end
      default: begin
        if (w_cls == CLS_C)      w_state_nxt = TX_C;
        else if (w_cls == CLS_S) w_state_nxt = TX_D;
      end
    endcase
  end

  assign w_force_e = (w_state_nxt == TX_E);
`else
  assign w_force_e = (w_cls == CLS_E);
`endif

  // Single-flop release synchroniser: first word accepted on the second edge after release.
  always_ff @(posedge i_txc or negedge i_reset_n) begin
    if (!i_reset_n) r_rst_sync <= 1'b0;
    else            r_rst_sync <= 1'b1;
  end

  always_ff @(posedge i_txc or negedge i_reset_n) begin
    if (!i_reset_n || !r_rst_sync) begin
      r_txd       <= IDLE_BLOCK;
      r_tx_header <= SYNC_CTL;
      r_tx_valid  <= 1'b0;
    end else begin
      r_tx_valid <= i_tx_valid & i_init_done;
      if (i_tx_valid && i_init_done) begin
        r_txd       <= w_force_e ? EBLOCK_T : w_enc;
        r_tx_header <= w_force_e ? SYNC_CTL : w_enc_hdr;
      end
    end
  end

  assign o_txd       = r_txd;
  assign o_tx_header = r_tx_header;
  assign o_tx_valid  = r_tx_valid;
endmodule

// File: tb/tb_encode_6466b_tx.sv
// tb/tb_encode_6466b_tx.sv - randomized self-checking bench for encode_6466b_tx.
`timescale 1ns/1ps
module tb_encode_6466b_tx;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        init_done = 1'b0;
  logic        tx_valid = 1'b0;
  logic [63:0] txd = '0;
  logic [7:0]  txctl = '0;
  logic [63:0] o_txd;
  logic [1:0]  o_hdr;
  logic        o_valid;
  int          n_cmp = 0;
  int          n_bad = 0;

  always #5 clk = ~clk;

  encode_6466b_tx dut (
    .i_txc(clk), .i_reset_n(rst_n), .i_init_done(init_done), .i_txd(txd),
    .i_txctl(txctl), .i_tx_valid(tx_valid), .o_txd(o_txd),
    .o_tx_header(o_hdr), .o_tx_valid(o_valid)
  );

  // Reference model: 66b blocks assembled field by field, LSB first, as in the block format tables.
  logic [63:0] m_acc;
  int          m_pos;
  int          m_mode;   // 0 = between frames, 1 = inside frame, 2 = error recovery
  logic [63:0] m_d;
  logic [1:0]  m_h;
  logic        m_v;

  function automatic logic [6:0] cc(input logic [7:0] ch);
    return (ch == 8'h07) ? 7'h00 : 7'h1E;
  endfunction

  task automatic put(input logic [63:0] v, input int w);
    m_acc = m_acc | ((v & ((64'h1 << w) - 64'h1)) << m_pos);
    m_pos += w;
  endtask

  task automatic model_eblock(output logic [63:0] blk);
    m_acc = '0; m_pos = 0;
    put(64'h1E, 8);
    for (int i = 0; i < 8; i++) put(64'h1E, 7);
    blk = m_acc;
  endtask

  task automatic model_encode(input logic [63:0] d, input logic [7:0] c,
                              output logic [63:0] blk, output logic [1:0] hdr, output byte cls);
    logic [7:0] b [8];
    logic [7:0] tt [8];
    logic [7:0] lo, up, ty;
    int f;
    logic tail_ok;
    tt = '{8'h87, 8'h99, 8'hAA, 8'hB4, 8'hCC, 8'hD2, 8'hE1, 8'hFF};
    for (int i = 0; i < 8; i++) b[i] = d[8*i +: 8];
    m_acc = '0; m_pos = 0; hdr = 2'b10; blk = '0; cls = "E";
    f = 8;
    for (int i = 7; i >= 0; i--) if (c[i]) f = i;
    tail_ok = 1'b1;
    for (int i = 0; i < 8; i++) if (i > f && !c[i]) tail_ok = 1'b0;
    lo = "?"; up = "?";
    if (c[3:0] == 4'hF && !(b[0] inside {8'hFB, 8'hFD}) && !(b[1] inside {8'hFB, 8'hFD})
        && !(b[2] inside {8'hFB, 8'hFD}) && !(b[3] inside {8'hFB, 8'hFD})) lo = "C";
    else if (c[3:0] == 4'h1 && b[0] == 8'h9C) lo = "O";
    if (c[7:4] == 4'hF && !(b[4] inside {8'hFB, 8'hFD}) && !(b[5] inside {8'hFB, 8'hFD})
        && !(b[6] inside {8'hFB, 8'hFD}) && !(b[7] inside {8'hFB, 8'hFD})) up = "C";
    else if (c[7:4] == 4'h1 && b[4] == 8'h9C) up = "O";
    else if (c[7:4] == 4'h1 && b[4] == 8'hFB) up = "S";
    if (c == 8'h00) begin
      blk = d; hdr = 2'b01; cls = "D";
    end else if (c == 8'h01 && b[0] == 8'hFB) begin
      put(64'h78, 8);
      for (int i = 1; i < 8; i++) put(64'(b[i]), 8);
      blk = m_acc; cls = "S";
    end else if (b[f] == 8'hFD && tail_ok) begin
      put(64'(tt[f]), 8);
      for (int i = 0; i < f; i++) put(64'(b[i]), 8);
      put(64'h0, 7 - f);
      for (int i = f + 1; i < 8; i++) put(64'(cc(b[i])), 7);
      blk = m_acc; cls = "T";
    end else if (lo != "?" && up != "?") begin
      case ({lo, up})
        "CC":    ty = 8'h1E;
        "CO":    ty = 8'h2D;
        "CS":    ty = 8'h33;
        "OC":    ty = 8'h4B;
        "OO":    ty = 8'h55;
        default: ty = 8'h66;
      endcase
      put(64'(ty), 8);
      if (lo == "C") for (int i = 0; i < 4; i++) put(64'(cc(b[i])), 7);
      else begin for (int i = 1; i < 4; i++) put(64'(b[i]), 8); put(64'h0, 4); end
      if (up == "C") for (int i = 4; i < 8; i++) put(64'(cc(b[i])), 7);
      else begin put(64'h0, 4); for (int i = 5; i < 8; i++) put(64'(b[i]), 8); end
      blk = m_acc; cls = (up == "S") ? "S" : "C";
    end else begin
      model_eblock(blk);
    end
  endtask

  task automatic model_reset();
    m_d = 64'h1E; m_h = 2'b10; m_v = 1'b0; m_mode = 0;
  endtask

  task automatic model_step(input logic [63:0] d, input logic [7:0] c, input logic v, input logic init);
    logic [63:0] blk;
    logic [1:0]  hdr;
    byte         cls;
    logic        err;
    m_v = v && init;
    if (!init) m_mode = 0;
    else if (v) begin
      model_encode(d, c, blk, hdr, cls);
      err = (cls == "E");
`ifdef ENCODER_TX_SM_EN
      case (m_mode)
        0: begin err = err || !(cls == "C" || cls == "S"); m_mode = err ? 2 : (cls == "S" ? 1 : 0); end
        1: begin err = err || !(cls == "D" || cls == "T"); m_mode = err ? 2 : (cls == "T" ? 0 : 1); end
        default: begin err = err || (cls == "S"); m_mode = err ? 2 : (cls == "D" ? 1 : 0); end
      endcase
`endif
      if (err) begin model_eblock(blk); hdr = 2'b10; end
      m_d = blk; m_h = hdr;
    end
  endtask

  task automatic cycle(input logic [63:0] d, input logic [7:0] c, input logic v);
    txd = d; txctl = c; tx_valid = v;
    model_step(d, c, v, init_done);
    @(posedge clk); #1;
  endtask

  function automatic logic [7:0] rand_ctl();
    case ($urandom_range(0, 3))
      0, 1:    return 8'h07;
      2:       return 8'hFE;
      default: return 8'h1C;
    endcase
  endfunction

  task automatic gen_word(input int kind, output logic [63:0] d, output logic [7:0] c);
    int k;
    d = {$urandom, $urandom}; c = 8'h00;
    case (kind)
      0: begin c = 8'hFF; d = {8{8'h07}}; end
      1: begin c = 8'hFF; for (int i = 0; i < 8; i++) d[8*i +: 8] = rand_ctl(); end
      2: c = 8'h00;
      3: begin c = 8'h01; d[7:0] = 8'hFB; end
      4: begin c = 8'h1F; for (int i = 0; i < 4; i++) d[8*i +: 8] = rand_ctl(); d[39:32] = 8'hFB; end
      5: begin c = 8'hF1; d[7:0] = 8'h9C; for (int i = 4; i < 8; i++) d[8*i +: 8] = rand_ctl(); end
      6: begin c = 8'h1F; for (int i = 0; i < 4; i++) d[8*i +: 8] = rand_ctl(); d[39:32] = 8'h9C; end
      7: begin c = 8'h11; d[7:0] = 8'h9C; d[39:32] = 8'h9C; end
      8: begin c = 8'h11; d[7:0] = 8'h9C; d[39:32] = 8'hFB; end
      9, 10: begin
        k = $urandom_range(0, 7); c = 8'hFF << k; d[8*k +: 8] = 8'hFD;
        for (int i = k + 1; i < 8; i++) d[8*i +: 8] = rand_ctl();
      end
      11: c = 8'($urandom);
      12: begin k = $urandom_range(0, 6); c = (8'hFF << k) & 8'h7F; d[8*k +: 8] = 8'hFD; end
      default: begin c = 8'hFF; d = {8{8'h07}}; d[8*$urandom_range(1, 7) +: 8] = 8'hFB; end
    endcase
  endtask

  task automatic test_reset();
    rst_n = 1'b0; init_done = 1'b1; model_reset();
    for (int i = 0; i < 3; i++) begin
      txd = {$urandom, $urandom}; txctl = 8'h00; tx_valid = 1'b1;
      @(posedge clk); #1;
      n_cmp++;
      if ({o_valid, o_hdr, o_txd} !== {1'b0, 2'b10, 64'h1E}) begin
        n_bad++;
        $display("FAIL reset_state: got valid=%0b hdr=%b txd=%h, want valid=0 hdr=10 txd=%h", o_valid, o_hdr, o_txd, 64'h1E);
      end
    end
  endtask

  task automatic test_idle();
    rst_n = 1'b1;
    txd = {8{8'h07}}; txctl = 8'hFF; tx_valid = 1'b1;
    @(posedge clk); #1;
    n_cmp++;
    if (o_valid !== 1'b0) begin
      n_bad++; $display("FAIL reset_sync_first_edge: got valid=%0b, want 0", o_valid);
    end
    for (int i = 0; i < 4; i++) begin
      cycle({8{8'h07}}, 8'hFF, 1'b1);
      n_cmp++;
      if ({o_valid, o_hdr, o_txd} !== {1'b1, 2'b10, 64'h1E} || {o_valid, o_hdr, o_txd} !== {m_v, m_h, m_d}) begin
        n_bad++;
        $display("FAIL idle_block[%0d]: got valid=%0b hdr=%b txd=%h, want valid=1 hdr=10 txd=%h", i, o_valid, o_hdr, o_txd, 64'h1E);
      end
    end
  endtask

  task automatic test_frame();
    logic [63:0] d [4];
    logic [7:0]  c [4];
    logic [7:0]  want_ty [4];
    want_ty = '{8'h78, 8'h00, 8'h00, 8'hB4};
    d[0] = {$urandom, $urandom}; d[0][7:0] = 8'hFB; c[0] = 8'h01;
    d[1] = {$urandom, $urandom}; c[1] = 8'h00;
    d[2] = {$urandom, $urandom}; c[2] = 8'h00;
    d[3] = {{4{8'h07}}, 8'hFD, 24'($urandom)}; c[3] = 8'hF8;
    for (int i = 0; i < 4; i++) begin
      cycle(d[i], c[i], 1'b1);
      n_cmp++;
      if ({o_valid, o_hdr, o_txd} !== {m_v, m_h, m_d}) begin
        n_bad++;
        $display("FAIL frame_word[%0d]: got valid=%0b hdr=%b txd=%h, want valid=%0b hdr=%b txd=%h", i, o_valid, o_hdr, o_txd, m_v, m_h, m_d);
      end
      n_cmp++;
      if ((c[i] == 8'h00 && o_hdr !== 2'b01) ||
          (c[i] != 8'h00 && (o_hdr !== 2'b10 || o_txd[7:0] !== want_ty[i])) ||
          (i == 3 && o_txd[31:8] !== d[3][23:0])) begin
        n_bad++;
        $display("FAIL frame_fields[%0d]: got hdr=%b type=%h txd=%h", i, o_hdr, o_txd[7:0], o_txd);
      end
    end
  endtask

  task automatic test_sequence();
    logic [63:0] dw;
    cycle({8{8'h07}}, 8'hFF, 1'b1);
    dw = {$urandom, $urandom};
    cycle(dw, 8'h00, 1'b1);
    n_cmp++;
`ifdef ENCODER_TX_SM_EN
    if ({o_hdr, o_txd} !== {2'b10, 64'h3C78_F1E3_C78F_1E1E} || {o_hdr, o_txd} !== {m_h, m_d}) begin
`else
    if ({o_hdr, o_txd} !== {2'b01, dw} || {o_hdr, o_txd} !== {m_h, m_d}) begin
`endif
      n_bad++;
      $display("FAIL data_after_idle: got hdr=%b txd=%h, want hdr=%b txd=%h", o_hdr, o_txd, m_h, m_d);
    end
    cycle({8{8'h07}}, 8'hFF, 1'b1);
    n_cmp++;
    if ({o_valid, o_hdr, o_txd} !== {1'b1, 2'b10, 64'h1E}) begin
      n_bad++;
      $display("FAIL idle_after_data: got valid=%0b hdr=%b txd=%h, want valid=1 hdr=10 txd=%h", o_valid, o_hdr, o_txd, 64'h1E);
    end
  endtask

  task automatic test_bad_start();
    logic [63:0] dw;
    dw = {8{8'h07}}; dw[23:16] = 8'hFB;
    cycle(dw, 8'h04, 1'b1);
    n_cmp++;
    if ({o_valid, o_hdr, o_txd} !== {1'b1, 2'b10, 64'h3C78_F1E3_C78F_1E1E}) begin
      n_bad++;
      $display("FAIL start_lane2: got valid=%0b hdr=%b txd=%h, want valid=1 hdr=10 txd=%h", o_valid, o_hdr, o_txd, 64'h3C78_F1E3_C78F_1E1E);
    end
    cycle({8{8'h07}}, 8'hFF, 1'b1);
  endtask

  task automatic test_random();
    logic [63:0] d;
    logic [7:0]  c;
    int bad_here;
    bad_here = 0;
    for (int i = 0; i < 400; i++) begin
      gen_word($urandom_range(0, 13), d, c);
      cycle(d, c, ($urandom_range(0, 7) != 0));
      n_cmp++;
      if ({o_valid, o_hdr, o_txd} !== {m_v, m_h, m_d}) begin
        n_bad++;
        if (bad_here++ < 10)
          $display("FAIL random[%0d] (txctl=%h txd=%h): got valid=%0b hdr=%b txd=%h, want valid=%0b hdr=%b txd=%h", i, c, d, o_valid, o_hdr, o_txd, m_v, m_h, m_d);
      end
    end
  endtask

  task automatic test_pause();
    logic [63:0] d;
    logic [7:0]  c;
    int n_acc, n_out;
    n_acc = 0; n_out = 0;
    cycle({8{8'h07}}, 8'hFF, 1'b1);
    for (int i = 0; i < 100; i++) begin
      if (i % 32 == 31) begin
        cycle({$urandom, $urandom}, 8'($urandom), 1'b0);
      end else begin
        if (n_acc == 0)       gen_word(3, d, c);
        else if (n_acc == 95) gen_word(9, d, c);
        else                  gen_word(2, d, c);
        cycle(d, c, 1'b1);
        n_acc++;
      end
      if (o_valid === 1'b1) n_out++;
      n_cmp++;
      if ({o_valid, o_hdr, o_txd} !== {m_v, m_h, m_d}) begin
        n_bad++;
        $display("FAIL pause[%0d]: got valid=%0b hdr=%b txd=%h, want valid=%0b hdr=%b txd=%h", i, o_valid, o_hdr, o_txd, m_v, m_h, m_d);
      end
    end
    n_cmp++;
    if (n_out != n_acc) begin
      n_bad++; $display("FAIL pause_block_count: got %0d valid blocks, want %0d", n_out, n_acc);
    end
  endtask

  task automatic test_init_done();
    logic [63:0] d;
    logic [7:0]  c;
    gen_word(0, d, c); cycle(d, c, 1'b1);
    gen_word(3, d, c); cycle(d, c, 1'b1);
    gen_word(2, d, c); cycle(d, c, 1'b1);
    init_done = 1'b0;
    gen_word(2, d, c); cycle(d, c, 1'b1);
    n_cmp++;
    if ({o_valid, o_hdr, o_txd} !== {1'b0, m_h, m_d}) begin
      n_bad++;
      $display("FAIL init_low_hold: got valid=%0b hdr=%b txd=%h, want valid=0 hdr=%b txd=%h", o_valid, o_hdr, o_txd, m_h, m_d);
    end
    init_done = 1'b1;
    for (int i = 0; i < 3; i++) begin
      gen_word((i == 2) ? 9 : 2, d, c); cycle(d, c, 1'b1);
      n_cmp++;
      if ({o_valid, o_hdr, o_txd} !== {m_v, m_h, m_d}) begin
        n_bad++;
        $display("FAIL init_resume[%0d]: got valid=%0b hdr=%b txd=%h, want valid=%0b hdr=%b txd=%h", i, o_valid, o_hdr, o_txd, m_v, m_h, m_d);
      end
    end
  endtask

  task automatic test_reset_midframe();
    logic [63:0] d;
    logic [7:0]  c;
    gen_word(0, d, c); cycle(d, c, 1'b1);
    gen_word(3, d, c); cycle(d, c, 1'b1);
    gen_word(2, d, c); cycle(d, c, 1'b1);
    txd = {$urandom, $urandom}; txctl = 8'h00;
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    n_cmp++;
    if ({o_valid, o_hdr, o_txd} !== {1'b0, 2'b10, 64'h1E}) begin
      n_bad++;
      $display("FAIL async_reset_midframe: got valid=%0b hdr=%b txd=%h, want valid=0 hdr=10 txd=%h", o_valid, o_hdr, o_txd, 64'h1E);
    end
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    cycle({8{8'h07}}, 8'hFF, 1'b0);
    gen_word(3, d, c); cycle(d, c, 1'b1);
    n_cmp++;
    if ({o_valid, o_hdr, o_txd[7:0]} !== {1'b1, 2'b10, 8'h78} || o_txd !== m_d) begin
      n_bad++;
      $display("FAIL s0_after_reset: got valid=%0b hdr=%b txd=%h, want valid=1 hdr=10 txd=%h", o_valid, o_hdr, o_txd, m_d);
    end
  endtask

  initial begin
    test_reset();
    test_idle();
    test_frame();
    test_sequence();
    test_bad_start();
    test_random();
    test_pause();
    test_init_done();
    test_reset_midframe();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
